dir_req_arbiter: RTL and testbench
==================================

DIR_REQ_ARBITER -- requirements
Module: dir_req_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 15, maximum cycles spent in WAIT before abort (1..15; 4-bit counter).
REQ-002 SHALL have port: Clock  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: ReqP0 / ReqP1  in  1  level request from cache P0,0 / P0,1.
REQ-005 SHALL have ports: SigP0 / SigP1  in  3  request code (001 ReadMiss, 010 WriteMiss; all others illegal).
REQ-006 SHALL have ports: AddrP0 / AddrP1  in  4  block address code (0001..1000).
REQ-007 SHALL have ports: DataP0 / DataP1  in  4  write data code (WriteMiss only).
REQ-008 SHALL have ports: AckP0 / AckP1  out  1  response valid to P0,0 / P0,1.
REQ-009 SHALL have ports: RspData  out  4  reply data; RspCode  out  2  sharer signal code; Err  out  1  request rejected or timed out.
REQ-010 SHALL have ports: DirValid  out  1  one-cycle directory request strobe; DirSig  out  3; DirAddr  out  4; DirData  out  4; DirProc  out  2  (00 P0,0, 01 P0,1).
REQ-011 SHALL have ports: DirDone  in  1  directory completion strobe; DirRspData  in  4; DirRspCode  in  2.
REQ-012 SHALL have port: Busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 SHALL, in IDLE with at least one Req high, grant one requester, latch its Sig/Addr/Data and id, and go to ISSUE next cycle.
REQ-015 SHALL arbitrate round-robin: single requester wins; on tie the requester not equal to LastGrant wins; LastGrant updates to the granted id at grant.
REQ-016 SHALL, in ISSUE with a legal latched Sig, drive DirValid=1 for exactly that one cycle with DirSig/DirAddr/DirData/DirProc from the latch, then go to WAIT.
REQ-017 SHALL, in ISSUE with an illegal latched Sig, skip the directory (DirValid=0), set Err=1, RspData=0000, RspCode=00, and go to RESP.
REQ-018 SHALL hold DirSig/DirAddr/DirData/DirProc stable from ISSUE until leaving WAIT; DirValid is 0 outside ISSUE.
REQ-019 SHALL ignore DirDone in IDLE, ISSUE and RESP.
REQ-020 SHALL, in WAIT on DirDone=1, capture DirRspData/DirRspCode into RspData/RspCode, Err=0, go to RESP.
REQ-021 SHALL count WAIT cycles from 0; if the count reaches TIMEOUT without DirDone, set Err=1, RspData=0000, RspCode=00, go to RESP; DirDone arriving in that same cycle wins over timeout.
REQ-022 SHALL, in RESP, assert only the granted requester's Ack and hold Ack, RspData, RspCode, Err stable until that requester's Req is low (4-phase handshake), then return to IDLE with Ack=0.
REQ-023 SHALL not re-sample the granted requester's Req in the cycle that RESP exits; the other requester may be granted on the following IDLE cycle.
REQ-024 SHALL keep minimum latency Req-high-in-IDLE to Ack at 3 cycles when DirDone arrives on the first WAIT cycle.
REQ-025 SHALL hold the losing requester pending with no Ack; its Req stays high without penalty.

Reset
REQ-026 SHALL, on Reset=1 at a clock edge, force IDLE, LastGrant=01 (P0,0 wins first tie), WAIT counter=0, latches=0.
REQ-027 SHALL drive all outputs to 0 during and after reset until a new grant: AckP0, AckP1, Err, DirValid, Busy=0; RspData, DirData, DirAddr=0000; RspCode, DirProc=00; DirSig=000.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation; a late DirDone is ignored per REQ-019.

Verification
REQ-029 SHALL pass: ReqP0=1, SigP0=001, AddrP0=0001; DirDone one cycle after DirValid with DirRspData=0110, DirRspCode=01 -> DirValid with DirAddr=0001, DirProc=00; AckP0=1, RspData=0110, RspCode=01, Err=0 at cycle 3; Ack held until ReqP0 drops.
REQ-030 SHALL pass: ReqP0 and ReqP1 rise together after reset -> P0,0 served first, then P0,1 (DirProc=01); repeated simultaneous requests alternate.
REQ-031 SHALL pass: ReqP1=1, SigP1=011 (Fetch) -> no DirValid, AckP1=1, Err=1, RspData=0000.
REQ-032 SHALL pass: WriteMiss SigP0=010, DataP0=1000, DirDone never asserted -> DirData=1000 held; after 15 WAIT cycles AckP0=1, Err=1; later DirDone ignored.
REQ-033 SHALL pass: Reset asserted during WAIT, DirDone one cycle later -> all outputs 0, no Ack, state IDLE; next ReqP1 handled normally.

Source files
------------

// File: rtl/dir_req_arbiter.sv
// Two-port request arbiter in front of a directory: grants one cache, forwards its
// request as a single strobe, waits (bounded) for completion and returns a 4-phase ack.
module dir_req_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ReqP0,
    input  logic       ReqP1,
    input  logic [2:0] SigP0,
    input  logic [2:0] SigP1,
    input  logic [3:0] AddrP0,
    input  logic [3:0] AddrP1,
    input  logic [3:0] DataP0,
    input  logic [3:0] DataP1,
    output logic       AckP0,
    output logic       AckP1,
    output logic [3:0] RspData,
    output logic [1:0] RspCode,
    output logic       Err,
    output logic       DirValid,
    output logic [2:0] DirSig,
    output logic [3:0] DirAddr,
    output logic [3:0] DirData,
    output logic [1:0] DirProc,
    input  logic       DirDone,
    input  logic [3:0] DirRspData,
    input  logic [1:0] DirRspCode,
    output logic       Busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;     // id of the most recent grant (1 = P0,1)
    logic       proc_q, proc_d;
    logic [2:0] sig_q, sig_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] data_q, data_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_code_q, rsp_code_d;
    logic       err_q, err_d;

    logic       grant_p1;
    logic       sig_legal;
    logic       owner_req;

    // P0,1 wins when alone, or on a tie when P0,0 was served last.
    assign grant_p1  = ReqP1 && (!ReqP0 || !last_q);
    assign sig_legal = (sig_q == 3'b001) || (sig_q == 3'b010);
    assign owner_req = proc_q ? ReqP1 : ReqP0;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        proc_d     = proc_q;
        sig_d      = sig_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_code_d = rsp_code_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (ReqP0 || ReqP1) begin
                    state_d    = ISSUE;
                    proc_d     = grant_p1;
                    last_d     = grant_p1;
                    sig_d      = grant_p1 ? SigP1  : SigP0;
                    addr_d     = grant_p1 ? AddrP1 : AddrP0;
                    data_d     = grant_p1 ? DataP1 : DataP0;
                    rsp_data_d = 4'b0000;
                    rsp_code_d = 2'b00;
                    err_d      = 1'b0;
                end
            end
            ISSUE: begin
                cnt_d = 4'd0;
                if (sig_legal) begin
                    state_d = WAIT;
                end else begin
                    state_d    = RESP;
                    err_d      = 1'b1;
                    rsp_data_d = 4'b0000;
                    rsp_code_d = 2'b00;
                end
            end
            WAIT: begin
                // A completion in the final allowed cycle beats the timeout.
                if (DirDone) begin
                    state_d    = RESP;
                    rsp_data_d = DirRspData;
                    rsp_code_d = DirRspCode;
                    err_d      = 1'b0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d    = RESP;
                    err_d      = 1'b1;
                    rsp_data_d = 4'b0000;
                    rsp_code_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            proc_q     <= 1'b0;
            sig_q      <= 3'b000;
            addr_q     <= 4'b0000;
            data_q     <= 4'b0000;
            cnt_q      <= 4'd0;
            rsp_data_q <= 4'b0000;
            rsp_code_q <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            proc_q     <= proc_d;
            sig_q      <= sig_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_code_q <= rsp_code_d;
            err_q      <= err_d;
        end
    end

    assign Busy     = (state_q != IDLE);
    assign DirValid = (state_q == ISSUE) && sig_legal;
    assign DirSig   = sig_q;
    assign DirAddr  = addr_q;
    assign DirData  = data_q;
    assign DirProc  = {1'b0, proc_q};
    assign AckP0    = (state_q == RESP) && !proc_q;
    assign AckP1    = (state_q == RESP) && proc_q;
    assign RspData  = rsp_data_q;
    assign RspCode  = rsp_code_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_dir_req_arbiter.sv
// Directed bench for dir_req_arbiter: each scenario task drives vectors and checks
// hand-derived values one cycle at a time, sampling 1 ns after the rising edge.
module tb_dir_req_arbiter;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       ReqP0, ReqP1;
    logic [2:0] SigP0, SigP1;
    logic [3:0] AddrP0, AddrP1, DataP0, DataP1;
    logic       AckP0, AckP1;
    logic [3:0] RspData;
    logic [1:0] RspCode;
    logic       Err, DirValid;
    logic [2:0] DirSig;
    logic [3:0] DirAddr, DirData;
    logic [1:0] DirProc;
    logic       DirDone;
    logic [3:0] DirRspData;
    logic [1:0] DirRspCode;
    logic       Busy;

    int n_cmp = 0;
    int n_bad = 0;

    dir_req_arbiter #(.TIMEOUT(15)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqP0(ReqP0), .ReqP1(ReqP1),
        .SigP0(SigP0), .SigP1(SigP1),
        .AddrP0(AddrP0), .AddrP1(AddrP1),
        .DataP0(DataP0), .DataP1(DataP1),
        .AckP0(AckP0), .AckP1(AckP1),
        .RspData(RspData), .RspCode(RspCode), .Err(Err),
        .DirValid(DirValid), .DirSig(DirSig), .DirAddr(DirAddr),
        .DirData(DirData), .DirProc(DirProc),
        .DirDone(DirDone), .DirRspData(DirRspData), .DirRspCode(DirRspCode),
        .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({AckP0, AckP1, Err, DirValid, Busy, RspData, RspCode, DirSig, DirAddr, DirData, DirProc} !== 24'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {AckP0, AckP1, Err, DirValid, Busy, RspData, RspCode, DirSig, DirAddr, DirData, DirProc});
        end
        Reset = 1'b0;
        tick();
        $display("reset: outputs after reset checked");
    endtask

    task automatic test_read_miss();
        ReqP0 = 1'b1; SigP0 = 3'b001; AddrP0 = 4'b0001; DataP0 = 4'b0000;
        tick();  // ISSUE
        n_cmp++;
        if ({DirValid, DirSig, DirAddr, DirProc, Busy} !== {1'b1, 3'b001, 4'b0001, 2'b00, 1'b1}) begin
            n_bad++;
            $display("FAIL read_issue: got v=%b sig=%b addr=%b proc=%b busy=%b required 1 001 0001 00 1",
                     DirValid, DirSig, DirAddr, DirProc, Busy);
        end
        tick();  // first WAIT cycle
        DirDone = 1'b1; DirRspData = 4'b0110; DirRspCode = 2'b01;
        n_cmp++;
        if ({DirValid, AckP0, DirAddr} !== {1'b0, 1'b0, 4'b0001}) begin
            n_bad++;
            $display("FAIL read_wait: got v=%b ack=%b addr=%b required 0 0 0001", DirValid, AckP0, DirAddr);
        end
        tick();  // RESP, cycle 3 after request
        DirDone = 1'b0;
        n_cmp++;
        if ({AckP0, AckP1, RspData, RspCode, Err} !== {1'b1, 1'b0, 4'b0110, 2'b01, 1'b0}) begin
            n_bad++;
            $display("FAIL read_ack: got ack0=%b ack1=%b data=%b code=%b err=%b required 1 0 0110 01 0",
                     AckP0, AckP1, RspData, RspCode, Err);
        end
        tick();
        tick();
        n_cmp++;
        if ({AckP0, RspData, RspCode} !== {1'b1, 4'b0110, 2'b01}) begin
            n_bad++;
            $display("FAIL read_hold: got ack0=%b data=%b code=%b required 1 0110 01", AckP0, RspData, RspCode);
        end
        ReqP0 = 1'b0;
        tick();
        n_cmp++;
        if ({AckP0, Busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL read_release: got ack0=%b busy=%b required 0 0", AckP0, Busy);
        end
        $display("read_miss: P0 read, ack after 3 cycles");
    endtask

    task automatic test_round_robin();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        SigP0 = 3'b001; AddrP0 = 4'b0010; SigP1 = 3'b001; AddrP1 = 4'b0100;
        for (int r = 0; r < 4; r++) begin
            logic exp_p1;
            exp_p1 = (r % 2) == 1;
            ReqP0 = 1'b1; ReqP1 = 1'b1;
            tick();  // ISSUE
            n_cmp++;
            if ({DirValid, DirProc, DirAddr} !== {1'b1, 1'b0, exp_p1, (exp_p1 ? 4'b0100 : 4'b0010)}) begin
                n_bad++;
                $display("FAIL rr_issue[%0d]: got v=%b proc=%b addr=%b required proc=0%b", r, DirValid, DirProc, DirAddr, exp_p1);
            end
            tick();  // WAIT
            DirDone = 1'b1; DirRspData = 4'(r + 3); DirRspCode = 2'b10;
            tick();  // RESP
            DirDone = 1'b0;
            n_cmp++;
            if ({AckP0, AckP1, RspData} !== {!exp_p1, exp_p1, 4'(r + 3)}) begin
                n_bad++;
                $display("FAIL rr_ack[%0d]: got ack0=%b ack1=%b data=%b required %b %b %b",
                         r, AckP0, AckP1, RspData, !exp_p1, exp_p1, 4'(r + 3));
            end
            if (exp_p1) ReqP1 = 1'b0; else ReqP0 = 1'b0;
            tick();  // back in IDLE
            n_cmp++;
            if ({AckP0, AckP1, Busy} !== 3'b000) begin
                n_bad++;
                $display("FAIL rr_idle[%0d]: got ack0=%b ack1=%b busy=%b required 000", r, AckP0, AckP1, Busy);
            end
            $display("round_robin: round %0d granted P0,%0d", r, exp_p1);
        end
        ReqP0 = 1'b0; ReqP1 = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        ReqP1 = 1'b1; SigP1 = 3'b011; AddrP1 = 4'b0011;
        tick();  // ISSUE
        n_cmp++;
        if ({DirValid, Busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL illegal_issue: got v=%b busy=%b required 0 1", DirValid, Busy);
        end
        tick();  // RESP
        n_cmp++;
        if ({AckP0, AckP1, Err, RspData, RspCode, DirValid} !== {1'b0, 1'b1, 1'b1, 4'b0000, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL illegal_ack: got ack0=%b ack1=%b err=%b data=%b code=%b v=%b required 0 1 1 0000 00 0",
                     AckP0, AckP1, Err, RspData, RspCode, DirValid);
        end
        ReqP1 = 1'b0;
        tick();
        $display("illegal: Fetch from P1 rejected");
    endtask

    task automatic test_timeout();
        int bad_wait;
        ReqP0 = 1'b1; SigP0 = 3'b010; AddrP0 = 4'b0011; DataP0 = 4'b1000;
        tick();  // ISSUE
        n_cmp++;
        if ({DirValid, DirSig, DirData} !== {1'b1, 3'b010, 4'b1000}) begin
            n_bad++;
            $display("FAIL timeout_issue: got v=%b sig=%b data=%b required 1 010 1000", DirValid, DirSig, DirData);
        end
        bad_wait = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if ({Busy, AckP0, DirValid, DirData} !== {1'b1, 1'b0, 1'b0, 4'b1000}) bad_wait++;
        end
        n_cmp++;
        if (bad_wait != 0) begin
            n_bad++;
            $display("FAIL timeout_wait: got %0d bad WAIT cycles required 0", bad_wait);
        end
        tick();  // RESP after 15 WAIT cycles
        n_cmp++;
        if ({AckP0, Err, RspData, RspCode} !== {1'b1, 1'b1, 4'b0000, 2'b00}) begin
            n_bad++;
            $display("FAIL timeout_ack: got ack0=%b err=%b data=%b code=%b required 1 1 0000 00", AckP0, Err, RspData, RspCode);
        end
        DirDone = 1'b1; DirRspData = 4'b1111; DirRspCode = 2'b11;
        tick();
        DirDone = 1'b0;
        n_cmp++;
        if ({AckP0, Err, RspData, RspCode} !== {1'b1, 1'b1, 4'b0000, 2'b00}) begin
            n_bad++;
            $display("FAIL timeout_late_done: got ack0=%b err=%b data=%b code=%b required 1 1 0000 00",
                     AckP0, Err, RspData, RspCode);
        end
        ReqP0 = 1'b0;
        tick();
        $display("timeout: WriteMiss aborted after 15 WAIT cycles");
    endtask

    task automatic test_done_at_limit();
        ReqP0 = 1'b1; SigP0 = 3'b001; AddrP0 = 4'b0111;
        tick();  // ISSUE
        for (int i = 0; i < 15; i++) tick();  // now in the 15th WAIT cycle
        DirDone = 1'b1; DirRspData = 4'b1010; DirRspCode = 2'b10;
        tick();
        DirDone = 1'b0;
        n_cmp++;
        if ({AckP0, Err, RspData, RspCode} !== {1'b1, 1'b0, 4'b1010, 2'b10}) begin
            n_bad++;
            $display("FAIL done_at_limit: got ack0=%b err=%b data=%b code=%b required 1 0 1010 10",
                     AckP0, Err, RspData, RspCode);
        end
        ReqP0 = 1'b0;
        tick();
        $display("done_at_limit: completion in last WAIT cycle accepted");
    endtask

    task automatic test_reset_mid();
        ReqP0 = 1'b1; SigP0 = 3'b001; AddrP0 = 4'b0001;
        tick();  // ISSUE
        tick();  // WAIT
        Reset = 1'b1;
        tick();
        Reset = 1'b0; ReqP0 = 1'b0;
        DirDone = 1'b1; DirRspData = 4'b1100; DirRspCode = 2'b11;
        tick();
        DirDone = 1'b0;
        n_cmp++;
        if ({AckP0, AckP1, Err, DirValid, Busy, RspData, RspCode, DirSig, DirAddr, DirData, DirProc} !== 24'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got %b required all zero",
                     {AckP0, AckP1, Err, DirValid, Busy, RspData, RspCode, DirSig, DirAddr, DirData, DirProc});
        end
        ReqP1 = 1'b1; SigP1 = 3'b001; AddrP1 = 4'b0101;
        tick();  // ISSUE
        n_cmp++;
        if ({DirValid, DirProc, DirAddr} !== {1'b1, 2'b01, 4'b0101}) begin
            n_bad++;
            $display("FAIL reset_mid_issue: got v=%b proc=%b addr=%b required 1 01 0101", DirValid, DirProc, DirAddr);
        end
        tick();  // WAIT
        DirDone = 1'b1; DirRspData = 4'b0011; DirRspCode = 2'b10;
        tick();  // RESP
        DirDone = 1'b0;
        n_cmp++;
        if ({AckP0, AckP1, Err, RspData, RspCode} !== {1'b0, 1'b1, 1'b0, 4'b0011, 2'b10}) begin
            n_bad++;
            $display("FAIL reset_mid_ack: got ack0=%b ack1=%b err=%b data=%b code=%b required 0 1 0 0011 10",
                     AckP0, AckP1, Err, RspData, RspCode);
        end
        ReqP1 = 1'b0;
        tick();
        $display("reset_mid: in-flight request abandoned, P1 then served");
    endtask

    initial begin
        Reset = 1'b1;
        ReqP0 = 1'b0; ReqP1 = 1'b0;
        SigP0 = 3'b000; SigP1 = 3'b000;
        AddrP0 = 4'b0000; AddrP1 = 4'b0000;
        DataP0 = 4'b0000; DataP1 = 4'b0000;
        DirDone = 1'b0; DirRspData = 4'b0000; DirRspCode = 2'b00;
        test_reset();
        test_read_miss();
        test_round_robin();
        test_illegal();
        test_timeout();
        test_done_at_limit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
